// File: rtl/taxi_mac_ctrl_pkg.sv
// Shared constants and request bundle for MAC control frame transmit.
// Used by the pause/PFC framer and its neighbours.
package taxi_mac_ctrl_pkg;

   localparam int MIN_FRAME_LEN = 60;
   localparam int MCF_HDR_LEN   = 16;

   localparam logic [15:0] ETH_TYPE_MCF  = 16'h8808;
   localparam logic [15:0] MCF_OPC_PAUSE = 16'h0001;
   localparam logic [15:0] MCF_OPC_PFC   = 16'h0101;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] eth_type;
      logic [15:0] opcode;
   } mcf_req_t;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } mcf_tx_state_e;

   function automatic int mcf_nbeats(input int keep_w);
      return (MIN_FRAME_LEN + keep_w - 1) / keep_w;
   endfunction

endpackage

// File: rtl/taxi_mac_mcf_tx_framer.sv
// MAC control frame serialiser: one captured request becomes a
// zero-padded 60-byte AXI-stream frame (FCS added downstream).
module taxi_mac_mcf_tx_framer
   import taxi_mac_ctrl_pkg::*;
#(
   parameter int DATA_W          = 64,
   parameter int MCF_PARAMS_SIZE = 18,
   parameter int KEEP_W          = DATA_W/8
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         mcf_valid,
   output logic                         mcf_ready,
   input  logic [47:0]                  mcf_eth_dst,
   input  logic [47:0]                  mcf_eth_src,
   input  logic [15:0]                  mcf_eth_type,
   input  logic [15:0]                  mcf_opcode,
   input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

   output logic [DATA_W-1:0]            m_axis_tdata,
   output logic [KEEP_W-1:0]            m_axis_tkeep,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tuser,

   output logic                         busy,
   output logic                         stat_tx_mcf
);

   localparam int NBEATS     = mcf_nbeats(KEEP_W);
   localparam int CW         = $clog2(NBEATS);
   localparam int IMG_W      = NBEATS*DATA_W;
   localparam int PW         = MCF_PARAMS_SIZE*8;
   localparam int LAST_LANES = MIN_FRAME_LEN - (NBEATS-1)*KEEP_W;

   localparam logic [CW-1:0]     LAST_BEAT = CW'(NBEATS-1);
   localparam logic [KEEP_W-1:0] KEEP_FULL = '1;
   localparam logic [KEEP_W-1:0] KEEP_LAST =
      KEEP_W'((64'd1 << LAST_LANES) - 64'd1);

   if (DATA_W != 8 && DATA_W != 16 &&
       DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $fatal(1, "DATA_W must be 8, 16, 32 or 64");
   end
   if (KEEP_W != DATA_W/8) begin : g_bad_keep_w
      $fatal(1, "KEEP_W must equal DATA_W/8");
   end
   if (MCF_PARAMS_SIZE < 2 || MCF_PARAMS_SIZE > 44) begin : g_bad_ps
      $fatal(1, "MCF_PARAMS_SIZE must be 2..44");
   end

   // Byte n of the frame sits at [8*n +: 8]; tail beyond 60 is zero.
   function automatic logic [IMG_W-1:0] build_img(
      input mcf_req_t        r,
      input logic [PW-1:0]   p
   );
      logic [IMG_W-1:0] img;
      img = '0;
      for (int k = 0; k < 6; k++) begin
         img[8*k +: 8]     = r.dst[8*(5-k) +: 8];
         img[8*(6+k) +: 8] = r.src[8*(5-k) +: 8];
      end
      img[8*12 +: 16]          = {r.eth_type[7:0], r.eth_type[15:8]};
      img[8*14 +: 16]          = {r.opcode[7:0], r.opcode[15:8]};
      img[8*MCF_HDR_LEN +: PW] = p;
      return img;
   endfunction

   mcf_tx_state_e       state_q;
   mcf_req_t            req_q;
   logic [PW-1:0]       params_q;
   logic [CW-1:0]       cnt_q;
   logic [DATA_W-1:0]   tdata_q;
   logic [KEEP_W-1:0]   tkeep_q;
   logic                tvalid_q;
   logic                tlast_q;
   logic                stat_q;

   mcf_req_t            req_d;
   logic [IMG_W-1:0]    img_hold;
   logic [DATA_W-1:0]   beat0_d;
   logic [DATA_W-1:0]   beat_d;
   logic [CW-1:0]       cnt_d;

   assign req_d.dst      = mcf_eth_dst;
   assign req_d.src      = mcf_eth_src;
   assign req_d.eth_type = mcf_eth_type;
   assign req_d.opcode   = mcf_opcode;

   // First beat comes straight from the request so it is on the bus
   // the cycle after capture; later beats come from the held image.
   assign beat0_d  = DATA_W'(build_img(req_d, mcf_params));
   assign img_hold = build_img(req_q, params_q);
   assign cnt_d    = cnt_q + CW'(1);
   assign beat_d   = img_hold[32'(cnt_d)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         params_q <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         stat_q   <= 1'b0;
      end else begin
         stat_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (mcf_valid) begin
                  req_q    <= req_d;
                  params_q <= mcf_params;
                  cnt_q    <= '0;
                  tdata_q  <= beat0_d;
                  tkeep_q  <= KEEP_FULL;
                  tlast_q  <= 1'b0;
                  tvalid_q <= 1'b1;
                  state_q  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (m_axis_tready) begin
                  if (cnt_q == LAST_BEAT) begin
                     tdata_q  <= '0;
                     tkeep_q  <= '0;
                     tlast_q  <= 1'b0;
                     tvalid_q <= 1'b0;
                     stat_q   <= 1'b1;
                     state_q  <= ST_IDLE;
                  end else begin
                     cnt_q   <= cnt_d;
                     tdata_q <= beat_d;
                     tkeep_q <= (cnt_d == LAST_BEAT) ? KEEP_LAST
                                                     : KEEP_FULL;
                     tlast_q <= (cnt_d == LAST_BEAT);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mcf_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q == ST_SEND);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = 1'b0;
   assign stat_tx_mcf   = stat_q;

endmodule

// File: tb/tb_taxi_mac_mcf_tx_framer.sv
// Directed bench for the MAC control frame framer (64-bit and 8-bit).
// Expected frames come from a byte-array model of the request fields.
module tb_taxi_mac_mcf_tx_framer;

   localparam int PS = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [47:0]   dst = '0, src = '0;
   logic [15:0]   typ = '0, opc = '0;
   logic [PS*8-1:0] prm = '0;

   logic        v64 = 1'b0, r64;
   logic [63:0] td64;
   logic [7:0]  tk64;
   logic        tv64, tl64, tu64, bz64, st64;
   logic        trdy64 = 1'b1;

   logic        v8 = 1'b0, r8;
   logic [7:0]  td8;
   logic [0:0]  tk8;
   logic        tv8, tl8, tu8, bz8, st8;
   logic        trdy8 = 1'b1;

   taxi_mac_mcf_tx_framer #(.DATA_W(64), .MCF_PARAMS_SIZE(PS)) u_dut64 (
      .clk(clk), .rst_n(rst_n),
      .mcf_valid(v64), .mcf_ready(r64),
      .mcf_eth_dst(dst), .mcf_eth_src(src),
      .mcf_eth_type(typ), .mcf_opcode(opc), .mcf_params(prm),
      .m_axis_tdata(td64), .m_axis_tkeep(tk64),
      .m_axis_tvalid(tv64), .m_axis_tready(trdy64),
      .m_axis_tlast(tl64), .m_axis_tuser(tu64),
      .busy(bz64), .stat_tx_mcf(st64)
   );

   taxi_mac_mcf_tx_framer #(.DATA_W(8), .MCF_PARAMS_SIZE(PS)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .mcf_valid(v8), .mcf_ready(r8),
      .mcf_eth_dst(dst), .mcf_eth_src(src),
      .mcf_eth_type(typ), .mcf_opcode(opc), .mcf_params(prm),
      .m_axis_tdata(td8), .m_axis_tkeep(tk8),
      .m_axis_tvalid(tv8), .m_axis_tready(trdy8),
      .m_axis_tlast(tl8), .m_axis_tuser(tu8),
      .busy(bz8), .stat_tx_mcf(st8)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  exp_b [128];
   logic [63:0] got_d [16];
   logic [7:0]  got_k [16];
   logic        got_l [16];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic build_exp();
      foreach (exp_b[i]) exp_b[i] = 8'h00;
      for (int k = 0; k < 6; k++) begin
         exp_b[k]   = dst[47-8*k -: 8];
         exp_b[6+k] = src[47-8*k -: 8];
      end
      exp_b[12] = typ[15:8];
      exp_b[13] = typ[7:0];
      exp_b[14] = opc[15:8];
      exp_b[15] = opc[7:0];
      for (int i = 0; i < PS; i++) exp_b[16+i] = prm[8*i +: 8];
   endtask

   function automatic logic [63:0] exp_beat(input int b);
      logic [63:0] e;
      for (int l = 0; l < 8; l++) e[8*l +: 8] = exp_b[8*b+l];
      return e;
   endfunction

   task automatic scramble();
      dst = ~dst; src = ~src; typ = ~typ; opc = ~opc; prm = ~prm;
   endtask

   task automatic req64(input logic [47:0] d, input logic [47:0] s,
                        input logic [15:0] t, input logic [15:0] o,
                        input logic [PS*8-1:0] p);
      @(negedge clk);
      dst = d; src = s; typ = t; opc = o; prm = p;
      build_exp();
      v64 = 1'b1;
      @(negedge clk);
      v64 = 1'b0;
      scramble();
   endtask

   // Called on the negedge where beat 0 should already be visible.
   task automatic collect64(input bit rnd);
      logic [63:0] pd = '0;
      logic [7:0]  pk = '0;
      logic        pl = 1'b0;
      bit          stall = 1'b0;
      bit          done = 1'b0;
      int          nb = 0;
      int          stats = 0;
      int          cyc = 0;
      chk("latency tvalid", tv64, 1);
      while (!done && cyc < 200) begin
         trdy64 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            chk("stall tvalid", tv64, 1);
            chk("stall tdata", td64, pd);
            chk("stall tkeep", tk64, pk);
            chk("stall tlast", tl64, pl);
         end
         chk("ready low in frame", r64, 0);
         stats += int'(st64);
         if (tv64 && trdy64) begin
            if (nb < 16) begin
               got_d[nb] = td64; got_k[nb] = tk64; got_l[nb] = tl64;
            end
            nb++;
            if (tl64) done = 1'b1;
         end
         pd = td64; pk = tk64; pl = tl64;
         stall = tv64 && !trdy64;
         cyc++;
         @(negedge clk);
      end
      trdy64 = 1'b1;
      chk("beat count", nb, 8);
      chk("stat during frame", stats, 0);
      chk("stat pulse", st64, 1);
      chk("ready after frame", r64, 1);
      chk("tvalid after frame", tv64, 0);
      chk("busy after frame", bz64, 0);
      chk("tuser", tu64, 0);
      for (int b = 0; b < 8 && b < nb; b++) begin
         chk($sformatf("b%0d tdata", b), got_d[b], exp_beat(b));
         chk($sformatf("b%0d tkeep", b), got_k[b], b == 7 ? 8'h0F : 8'hFF);
         chk($sformatf("b%0d tlast", b), got_l[b], b == 7);
      end
   endtask

   localparam logic [47:0] PAUSE_DST = 48'h0180C2000001;
   localparam logic [47:0] PAUSE_SRC = 48'h80233143544C;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PS*8-1:0] pfc_p;
      int nb;
      bit done;
      for (int i = 0; i < PS; i++) pfc_p[8*i +: 8] = 8'(8'hA0 + i);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst tvalid", tv64, 0);
      chk("rst tkeep", tk64, 0);
      chk("rst tdata", td64, 0);
      chk("rst tlast", tl64, 0);
      chk("rst tuser", tu64, 0);
      chk("rst busy", bz64, 0);
      chk("rst stat", st64, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready after rst", r64, 1);

      // pause frame, no backpressure
      req64(PAUSE_DST, PAUSE_SRC, 16'h8808, 16'h0001, 144'hFFFF);
      collect64(1'b0);
      chk("pause beat0", got_d[0], 64'h2380_0100_00C2_8001);
      chk("pause beat1", got_d[1], 64'h0100_0888_4C54_4331);
      chk("pause beat2", got_d[2], 64'h0000_0000_0000_FFFF);
      chk("pause beat7", got_d[7], 64'h0);
      chk("pause keep7", got_k[7], 8'h0F);

      // same frame with random backpressure
      req64(PAUSE_DST, PAUSE_SRC, 16'h8808, 16'h0001, 144'hFFFF);
      collect64(1'b1);
      chk("bp beat0", got_d[0], 64'h2380_0100_00C2_8001);
      chk("bp beat1", got_d[1], 64'h0100_0888_4C54_4331);

      // back-to-back with mcf_valid held high
      @(negedge clk);
      dst = PAUSE_DST; src = PAUSE_SRC; typ = 16'h8808;
      opc = 16'h0001; prm = 144'hFFFF;
      build_exp();
      v64 = 1'b1;
      @(negedge clk);
      dst = 48'h0180C2000001; src = 48'h0A0B0C0D0E0F;
      typ = 16'h8808; opc = 16'h0101; prm = pfc_p;
      collect64(1'b0);
      build_exp();
      @(negedge clk);
      v64 = 1'b0;
      scramble();
      collect64(1'b0);
      chk("b2b second opcode", got_d[1][63:48], 16'h0101);

      // reset while beat 3 is on the bus
      req64(48'h0180C2000001, 48'h001122334455, 16'h8808, 16'h0101, pfc_p);
      repeat (3) @(negedge clk);
      chk("pre-rst beat3", td64, exp_beat(3));
      chk("pre-rst tvalid", tv64, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-rst tvalid", tv64, 0);
      chk("mid-rst tkeep", tk64, 0);
      chk("mid-rst tdata", td64, 0);
      chk("mid-rst busy", bz64, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready after mid-rst", r64, 1);
      req64(48'h0180C2000001, 48'h665544332211, 16'h8808, 16'h0101, pfc_p);
      collect64(1'b0);

      // 8-bit instance, PFC frame
      @(negedge clk);
      dst = 48'h0180C2000001; src = 48'h0A0B0C0D0E0F;
      typ = 16'h8808; opc = 16'h0101; prm = pfc_p;
      build_exp();
      v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      scramble();
      nb = 0;
      done = 1'b0;
      chk("w8 latency", tv8, 1);
      for (int c = 0; c < 100 && !done; c++) begin
         if (tv8) begin
            chk($sformatf("w8 byte%0d", nb), td8, exp_b[nb]);
            chk($sformatf("w8 last%0d", nb), tl8, nb == 59);
            chk($sformatf("w8 keep%0d", nb), tk8, 1);
            nb++;
            if (tl8) done = 1'b1;
         end
         @(negedge clk);
      end
      chk("w8 beat count", nb, 60);
      chk("w8 stat pulse", st8, 1);
      chk("w8 ready after", r8, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/taxi_mac_mcf_tx_framer.md
# taxi_mac_mcf_tx_framer

Serialises one MAC control frame request into an AXI-stream Ethernet frame for the MAC transmit arbiter. It sits directly downstream of the pause/PFC transmit controller and consumes its `mcf_*` request handshake (dst, src, EtherType, opcode, params). It emits a zero-padded 60-byte frame without FCS; the MAC appends FCS. Frames are never truncated except by reset.

## Interface
- `DATA_W`, 64: stream width in bits; legal values are 8, 16, 32, 64.
- `MCF_PARAMS_SIZE`, 18: parameter field size in bytes, 2..44. Elaboration is fatal outside this range.
- `KEEP_W`, `DATA_W/8`: byte lanes (derived).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mcf_valid`  in  1  request valid.
- `mcf_ready`  out  1  request accepted when high with `mcf_valid`.
- `mcf_eth_dst`  in  48  destination MAC; bits [47:40] go on the wire first.
- `mcf_eth_src`  in  48  source MAC, MSB byte first.
- `mcf_eth_type`  in  16  EtherType, MSB byte first.
- `mcf_opcode`  in  16  opcode, MSB byte first.
- `mcf_params`  in  `MCF_PARAMS_SIZE*8`  parameter bytes; byte i = `[8*i +: 8]`, byte 0 first.
- `m_axis_tdata`  out  `DATA_W`  frame data; lane 0 = earliest byte.
- `m_axis_tkeep`  out  `KEEP_W`  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tuser`  out  1  error flag; always 0.
- `busy`  out  1  frame in progress.
- `stat_tx_mcf`  out  1  one-cycle pulse per completed frame.

## Operation
- Two states:
  - IDLE: `mcf_ready`=1.
  - SEND: `mcf_ready`=0.
- IDLE→SEND on `mcf_valid && mcf_ready`:
  - all request fields are captured into holding registers;
  - the beat counter clears to 0.
  - Input changes after capture have no effect.
- Frame byte n, 0..59:
  - 0–5: dst;
  - 6–11: src;
  - 12–13: type;
  - 14–15: opcode;
  - 16..15+`MCF_PARAMS_SIZE`: params;
  - remaining bytes: 0x00.
  - Frame length is fixed at 60 bytes (`MIN_FRAME_LEN`).
- In SEND: `tvalid`=1, and beat b carries bytes `b*KEEP_W .. b*KEEP_W+KEEP_W-1`.
- Beat count is `NBEATS = ceil(60/KEEP_W)`: 60/30/15/8 beats for DATA_W 8/16/32/64.
- `tkeep`:
  - all ones except the last beat;
  - last beat has the low `60 - (NBEATS-1)*KEEP_W` lanes set: 0x0F for DATA_W=64, 0xF for 32, 0b11 for 16, 0b1 for 8.
  - Unused lanes carry 0x00.
- `tlast`=1 only when beat counter = `NBEATS-1`.
- On `tvalid && tready`, the beat counter increments. On the last beat it instead returns to IDLE and pulses `stat_tx_mcf` in the following cycle.
- `busy` = (state == SEND).

## Timing
- Reset (async, `rst_n`=0), immediately:
  - state IDLE;
  - `mcf_ready`=1 after deassertion;
  - `m_axis_tvalid`=0, `tlast`=0, `tkeep`=0, `tdata`=0, `tuser`=0;
  - `busy`=0, `stat_tx_mcf`=0;
  - holding registers cleared.
- Reset mid-frame drops `tvalid` asynchronously and truncates the frame. This is accepted behaviour; the downstream arbiter is reset in the same domain.
- Latency: the first beat is valid in the cycle after capture.
- An unstalled frame occupies `NBEATS` cycles, followed by 1 idle bubble: `mcf_ready` rises the cycle after the last beat is accepted. Minimum request spacing is `NBEATS+1` cycles.
- AXI-stream stability: while `tvalid && !tready`, `tdata`/`tkeep`/`tlast` hold; `tvalid` never drops before acceptance.
- All stream outputs are driven from registers only; there is no combinational path from `m_axis_tready` or `mcf_*` to any output.
- A `mcf_valid` held high during SEND is ignored until IDLE; the request is then captured in the first IDLE cycle.
- Counter width is `$clog2(NBEATS)`, with no wrap (terminated at `NBEATS-1`).

## Structure
- Shared package `taxi_mac_ctrl_pkg` holds:
  - `MIN_FRAME_LEN`=60;
  - `MCF_HDR_LEN`=16;
  - EtherType constant 16'h8808;
  - opcode constants (pause 16'h0001, PFC 16'h0101);
  - an `mcf_req_t` struct of dst/src/type/opcode.
- The 60-byte frame image is built combinationally from the holding registers as a flat byte vector. Beat selection is an indexed part-select registered into the output stage.
- No sub-module is required.

## Test plan
- Pause request, DATA_W=64, dst 01:80:C2:00:00:01, src 80:23:31:43:54:4C, type 8808, opcode 0001, params byte0=FF byte1=FF, `tready`=1:
  - 8 beats;
  - beat0 tdata 0x2380_0100_00C2_8001;
  - beat1 0x0100_0888_4C54_4331;
  - beat2 low bytes FF FF;
  - last beat tkeep 0x0F, all-zero padding;
  - one `stat_tx_mcf` pulse.
- Random `tready` backpressure (50%) on the same frame: payload identical; outputs stable during every stall; `mcf_ready` stays 0 until one cycle after the last beat is accepted.
- DATA_W=8, PFC request with `MCF_PARAMS_SIZE`=18: 60 beats; bytes 16..33 equal params in order; bytes 34..59 are zero; `tlast` only on beat 59.
- `mcf_valid` held high continuously, two distinct requests, DATA_W=64: frames are back-to-back with exactly one idle cycle between them; the second frame reflects the second request.
- `rst_n` asserted at beat 3 of 8: `tvalid`=0 immediately. After release, `mcf_ready`=1 and a new request produces a complete, correct frame.
- Request fields changed while in SEND: the emitted frame matches the values present at capture.
